// File: rtl/bitty_uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and protocol
// flag bytes. The PARITY state exists only when UART_RX_PARITY_EN is defined.
package bitty_uart_pkg;

  localparam int DATA_W = 8;

  // Flag byte the host sends to request a fetch.
  localparam logic [7:0] FETCH_FLAG = 8'h03;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rx_state_e;

  // Even-parity bit for a data word: the XOR of all its bits.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset
// to 1 so an idle-high line never shows a false edge after reset.
module bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      // NOTE: non-blocking so q takes the old meta, giving two real stages.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, optional even-parity
// bit, 1 stop bit. Bits are sampled at mid-bit from the synchronized line.
// Define UART_RX_PARITY_EN to include the parity bit and parity_err;
// without it the frame is 10 bits and parity_err is tied low.
module uart_rx
  import bitty_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              rx_do,
  output logic [DATA_W-1:0] rx_data,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic              rxs;
  logic              rxs_prev;
  rx_state_e         state;
  logic [CW-1:0]     baud_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              par_bad;

  bit_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

`ifndef UART_RX_PARITY_EN
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Receive FSM: edge detect, mid-bit sampling, and registered result pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxs_prev   <= 1'b1;
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      // NOTE: the shift register is reset too, so no stale bits survive an abandoned frame.
      shift      <= '0;
      rx_data    <= '0;
      rx_do      <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rxs_prev  <= rxs;
      // NOTE: pulse outputs default low every cycle; only STOP raises them.
      rx_do     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (rxs_prev && !rxs) begin
            state    <= START;
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt       <= '0;
            shift[bit_cnt] <= rxs;
            bit_cnt        <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            par_bad  <= rxs ^ even_parity(shift);
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt  <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= !rxs;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            if (rxs && !par_bad) begin
              rx_data <= shift;
              rx_do   <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
